// File: rtl/hls_ctrl_pkg.sv
// Shared types for the ap_ctrl_hs initiator: FSM states, response status codes, default word width.
// Combinational helpers only; no state lives here.
package hls_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t STAT_OK          = 2'b00;
  localparam status_t STAT_TIMEOUT     = 2'b01;
  localparam status_t STAT_MISSING_VLD = 2'b10;

  // res1 is an ap_none inout, so only res0/res2 strobes are mandatory.
  function automatic status_t done_status(input logic got0, input logic got2);
    return (got0 && got2) ? STAT_OK : STAT_MISSING_VLD;
  endfunction

endpackage

// File: rtl/hls_ctrl_watchdog.sv
// Saturating cycle counter; expired flags the cycle whose increment reaches LIMIT.
// Zero latency on expired; clr wins over en, no backpressure.
module hls_ctrl_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Looks one count ahead so the owner can leave after exactly LIMIT enabled cycles.
  assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/hls_ap_ctrl_initiator.sv
// ap_ctrl_hs job initiator: registers args, pulses ap_start, captures result strobes, reports status.
// Response one cycle after ap_done/watchdog; one job in flight, req_ready low until rsp handshake.
module hls_ap_ctrl_initiator
  import hls_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_ARGS  = 21,
  parameter int INOUT_IDX = 20,
  parameter int TIMEOUT   = 255
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_ARGS*DATA_W-1:0] req_args,
  output logic [NUM_ARGS*DATA_W-1:0] arg_o,
  output logic                     ap_start,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  input  logic                     ap_ready,
  input  logic [DATA_W-1:0]        res0,
  input  logic                     res0_vld,
  input  logic [DATA_W-1:0]        res1,
  input  logic                     res1_vld,
  input  logic [DATA_W-1:0]        res2,
  input  logic                     res2_vld,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3*DATA_W-1:0]      rsp_data,
  output logic [1:0]               rsp_status,
  output logic                     busy
);

  localparam int ARGS_W = NUM_ARGS * DATA_W;

  state_e              state_q, state_d;
  logic [ARGS_W-1:0]   arg_q;
  logic [DATA_W-1:0]   res0_q, res1_q, res2_q;
  logic                flag0_q, flag2_q;
  status_t             status_q;

  logic accept;
  logic running;
  logic wd_expired;
  logic finish_done;
  logic finish_timeout;

  // ap_idle is informational only; control relies on ap_ready/ap_done.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  assign accept         = (state_q == ST_IDLE) && req_valid;
  assign running        = (state_q == ST_START) || (state_q == ST_WAIT);
  assign finish_done    = running && ap_done;
  assign finish_timeout = running && !ap_done && wd_expired;

  hls_ctrl_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .clr     (accept),
    .en      (running),
    .expired (wd_expired)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        // A done without ready still ends the job; done also beats a coincident expiry.
        if (ap_done)         state_d = ST_RESP;
        else if (ap_ready)   state_d = ST_WAIT;
        else if (wd_expired) state_d = ST_RESP;
      end
      ST_WAIT: begin
        if (ap_done || wd_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    ap_start  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_START: ap_start  = 1'b1;
      ST_WAIT:  ap_start  = 1'b0;
      ST_RESP:  rsp_valid = 1'b1;
      default:  busy      = 1'b0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      arg_q    <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
      res2_q   <= '0;
      flag0_q  <= 1'b0;
      flag2_q  <= 1'b0;
      status_q <= STAT_OK;
    end else if (accept) begin
      arg_q    <= req_args;
      res0_q   <= '0;
      res1_q   <= req_args[INOUT_IDX*DATA_W +: DATA_W];
      res2_q   <= '0;
      flag0_q  <= 1'b0;
      flag2_q  <= 1'b0;
      status_q <= STAT_OK;
    end else if (running) begin
      if (res0_vld) begin
        res0_q  <= res0;
        flag0_q <= 1'b1;
      end
      if (res1_vld) begin
        res1_q <= res1;
      end
      if (res2_vld) begin
        res2_q  <= res2;
        flag2_q <= 1'b1;
      end
      // Strobes landing with ap_done count toward the verdict.
      if (finish_done) begin
        status_q <= done_status(flag0_q || res0_vld, flag2_q || res2_vld);
      end else if (finish_timeout) begin
        status_q <= STAT_TIMEOUT;
      end
    end
  end

  assign arg_o      = arg_q;
  assign rsp_data   = {res2_q, res1_q, res0_q};
  assign rsp_status = status_q;

endmodule
